led_port_ctrl: RTL and testbench

- Memory-mapped, parametrised LED output port for the single-cycle MIPS core.
- Replaces the fixed led0..led7 wiring with an N-channel register-controlled port.
- Sits on the CPU data bus as a peripheral. Supports static on/off, per-channel blinking from a programmable prescaler, and register read-back.

---
 rtl/led_port_pkg.sv | 19 +
 rtl/led_blink_timer.sv | 62 ++++++
 rtl/led_port_ctrl.sv | 109 ++++++++++
 tb/tb_led_port_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/led_port_pkg.sv
// Shared constants for the LED output port: register word offsets, reset values
// and the blink timer state encoding.
package led_port_pkg;

  localparam int LED_REG_DATA   = 0;
  localparam int LED_REG_MODE   = 1;
  localparam int LED_REG_PERIOD = 2;
  localparam int LED_REG_SET    = 3;
  localparam int LED_REG_CLR    = 4;

  localparam logic [31:0] LED_RST_WORD  = 32'h0;
  localparam logic        LED_RST_PHASE = 1'b1;

  typedef enum logic {
    TMR_IDLE  = 1'b0,
    TMR_BLINK = 1'b1
  } tmr_state_t;

endpackage

// File: rtl/led_blink_timer.sv
// Blink prescaler: counts clk_in cycles up to the programmed half-period and
// toggles phase on each wrap. A period write restarts the count at phase=1.
//
//   state     | meaning
//   ----------+-------------------------------------------------
//   TMR_IDLE  | period is 0: cnt held at 0, phase held at 1
//   TMR_BLINK | period nonzero: cnt wraps at period-1, phase toggles
module led_blink_timer
  import led_port_pkg::*;
#(
  parameter int PRESCALE_W = 24
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic [PRESCALE_W-1:0] period,
  input  logic                  period_wr,
  output logic                  phase
);

  tmr_state_t            r_state;
  logic [PRESCALE_W-1:0] r_cnt;
  logic                  r_phase;
  logic                  w_wrap;

  // period carries the value being written on a period_wr cycle
  assign w_wrap = (r_cnt == (period - PRESCALE_W'(1)));

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      r_state <= TMR_IDLE;
      r_cnt   <= '0;
      r_phase <= LED_RST_PHASE;
    end else if (period_wr) begin
      r_state <= (period == '0) ? TMR_IDLE : TMR_BLINK;
      r_cnt   <= '0;
      r_phase <= LED_RST_PHASE;
    end else begin
      case (r_state)
        TMR_IDLE: begin
          r_cnt   <= '0;
          r_phase <= LED_RST_PHASE;
        end
        TMR_BLINK: begin
          if (w_wrap) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
          end else begin
            r_cnt <= r_cnt + PRESCALE_W'(1);
          end
        end
        default: begin
          r_state <= TMR_IDLE;
          r_cnt   <= '0;
          r_phase <= LED_RST_PHASE;
        end
      endcase
    end
  end

  assign phase = r_phase;

endmodule

// File: rtl/led_port_ctrl.sv
// Memory-mapped N-channel LED port: DATA/MODE/PERIOD registers, registered
// read-back and blink output stage. Define LED_PORT_SETCLR_EN for SET/CLR registers.
module led_port_ctrl
  import led_port_pkg::*;
#(
  parameter int                NUM_LEDS   = 8,
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'('h40),
  parameter int                PRESCALE_W = 24
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [31:0]         wdata,
  input  logic                we,
  input  logic                re,
  output logic [31:0]         rdata,
  output logic                rvalid,
  output logic [NUM_LEDS-1:0] leds
);

  logic [NUM_LEDS-1:0]   r_data;
  logic [NUM_LEDS-1:0]   r_mode;
  logic [PRESCALE_W-1:0] r_period;
  logic [NUM_LEDS-1:0]   r_leds;
  logic [31:0]           r_rdata;
  logic                  r_rvalid;

  logic [ADDR_W-1:0]     w_off;
  logic                  w_sel_data, w_sel_mode, w_sel_period, w_sel_set, w_sel_clr;
  logic [NUM_LEDS-1:0]   w_wd_leds;
  logic [PRESCALE_W-1:0] w_wd_period;
  logic [NUM_LEDS-1:0]   w_data_nxt;
  logic [PRESCALE_W-1:0] w_period_nxt;
  logic                  w_period_wr;
  logic [31:0]           w_rd_word;
  logic                  w_phase;
  logic                  w_unused_wdata;

  assign w_off        = addr - BASE_ADDR;
  assign w_sel_data   = (w_off == ADDR_W'(LED_REG_DATA));
  assign w_sel_mode   = (w_off == ADDR_W'(LED_REG_MODE));
  assign w_sel_period = (w_off == ADDR_W'(LED_REG_PERIOD));
`ifdef LED_PORT_SETCLR_EN
  assign w_sel_set    = (w_off == ADDR_W'(LED_REG_SET));
  assign w_sel_clr    = (w_off == ADDR_W'(LED_REG_CLR));
`else
  assign w_sel_set    = 1'b0;
  assign w_sel_clr    = 1'b0;
`endif

  // only the low bits of wdata are stored; the rest is deliberately dropped
  assign w_wd_leds      = wdata[NUM_LEDS-1:0];
  assign w_wd_period    = wdata[PRESCALE_W-1:0];
  assign w_unused_wdata = ^wdata;

  always_comb begin
    w_data_nxt = r_data;
    if (we) begin
      if (w_sel_data)     w_data_nxt = w_wd_leds;
      else if (w_sel_set) w_data_nxt = r_data | w_wd_leds;
      else if (w_sel_clr) w_data_nxt = r_data & ~w_wd_leds;
    end
  end

  assign w_period_wr  = we & w_sel_period;
  assign w_period_nxt = w_period_wr ? w_wd_period : r_period;

  // reads see the pre-write register contents
  always_comb begin
    w_rd_word = LED_RST_WORD;
    if (w_sel_data)        w_rd_word = 32'(r_data);
    else if (w_sel_mode)   w_rd_word = 32'(r_mode);
    else if (w_sel_period) w_rd_word = 32'(r_period);
  end

  led_blink_timer #(
    .PRESCALE_W (PRESCALE_W)
  ) u_timer (
    .clk_in    (clk_in),
    .reset     (reset),
    .period    (w_period_nxt),
    .period_wr (w_period_wr),
    .phase     (w_phase)
  );

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      r_data   <= NUM_LEDS'(LED_RST_WORD);
      r_mode   <= NUM_LEDS'(LED_RST_WORD);
      r_period <= PRESCALE_W'(LED_RST_WORD);
      r_leds   <= NUM_LEDS'(LED_RST_WORD);
      r_rdata  <= LED_RST_WORD;
      r_rvalid <= 1'b0;
    end else begin
      r_data   <= w_data_nxt;
      if (we && w_sel_mode) r_mode <= w_wd_leds;
      r_period <= w_period_nxt;
      r_leds   <= (r_data & ~r_mode) | (r_data & r_mode & {NUM_LEDS{w_phase}});
      r_rvalid <= re;
      if (re) r_rdata <= w_rd_word;
    end
  end

  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
  assign leds   = r_leds;

endmodule

// File: tb/tb_led_port_ctrl.sv
// Self-checking bench for led_port_ctrl: vector table for register access plus
// hand-written blink sequences; reads are checked through a scoreboard queue.
module tb_led_port_ctrl;
  import led_port_pkg::*;

`ifdef LED_PORT_SETCLR_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  logic        clk_in;
  logic        reset;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [31:0] rdata;
  logic        rvalid;
  logic [7:0]  leds;

  led_port_ctrl dut (
    .clk_in (clk_in),
    .reset  (reset),
    .addr   (addr),
    .wdata  (wdata),
    .we     (we),
    .re     (re),
    .rdata  (rdata),
    .rvalid (rvalid),
    .leds   (leds)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] data;
    int          due;
  } sb_t;

  typedef struct {
    bit          w;
    bit          r;
    int          off;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [7:0]  leds;
  } vec_t;

  sb_t  sb_q[$];
  sb_t  sb_e;
  vec_t vt[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  // read scoreboard: each expected read must appear exactly on its due cycle
  always @(posedge clk_in) begin
    cyc = cyc + 1;
    #2;
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      sb_e = sb_q.pop_front();
      checks++;
      if (rvalid !== 1'b1 || rdata !== sb_e.data) begin
        failures++;
        $display("FAIL read_resp cyc=%0d: got rvalid=%b rdata=%h expected rvalid=1 rdata=%h",
                 cyc, rvalid, rdata, sb_e.data);
      end
    end else if (rvalid !== 1'b0) begin
      checks++;
      failures++;
      $display("FAIL rvalid_unexpected cyc=%0d: got %b expected 0", cyc, rvalid);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input bit w, input bit r, input int off, input logic [31:0] d,
                      input logic [31:0] exp_rd);
    we    = w;
    re    = r;
    addr  = 8'h40 + 8'(off);
    wdata = d;
    if (r) sb_q.push_back('{exp_rd, cyc + 1});
    @(posedge clk_in);
    #1;
    we = 1'b0;
    re = 1'b0;
  endtask

  initial begin
    // static, unmapped and collision accesses (leds = value after that edge)
    vt.push_back('{1, 0, LED_REG_DATA,   32'h0000_00A5, 32'h0,  8'h00});
    vt.push_back('{0, 1, LED_REG_DATA,   32'h0,         32'hA5, 8'hA5});
    vt.push_back('{0, 0, LED_REG_DATA,   32'h0,         32'h0,  8'hA5});
    vt.push_back('{1, 0, 7,              32'hFFFF_FFFF, 32'h0,  8'hA5});
    vt.push_back('{0, 1, 7,              32'h0,         32'h0,  8'hA5});
    vt.push_back('{0, 1, LED_REG_DATA,   32'h0,         32'hA5, 8'hA5});
    vt.push_back('{1, 0, LED_REG_DATA,   32'h0000_0011, 32'h0,  8'hA5});
    vt.push_back('{1, 1, LED_REG_DATA,   32'h0000_0022, 32'h11, 8'h11});
    vt.push_back('{0, 1, LED_REG_DATA,   32'h0,         32'h22, 8'h22});
    vt.push_back('{0, 1, LED_REG_MODE,   32'h0,         32'h0,  8'h22});
    vt.push_back('{0, 1, LED_REG_PERIOD, 32'h0,         32'h0,  8'h22});
    vt.push_back('{0, 0, LED_REG_DATA,   32'h0,         32'h0,  8'h22});
    // SET/CLR: effective only with the optional registers present
    vt.push_back('{1, 0, LED_REG_DATA,   32'h0000_000F, 32'h0,  8'h22});
    vt.push_back('{1, 0, LED_REG_SET,    32'h0000_00F0, 32'h0,  8'h0F});
    vt.push_back('{0, 1, LED_REG_DATA,   32'h0,         SC ? 32'hFF : 32'h0F, SC ? 8'hFF : 8'h0F});
    vt.push_back('{1, 0, LED_REG_CLR,    32'h0000_0081, 32'h0,  SC ? 8'hFF : 8'h0F});
    vt.push_back('{0, 1, LED_REG_DATA,   32'h0,         SC ? 32'h7E : 32'h0F, SC ? 8'h7E : 8'h0F});
    vt.push_back('{0, 1, LED_REG_SET,    32'h0,         32'h0,  SC ? 8'h7E : 8'h0F});
    vt.push_back('{0, 1, LED_REG_CLR,    32'h0,         32'h0,  SC ? 8'h7E : 8'h0F});

    reset = 1'b0;
    we    = 1'b1;
    re    = 1'b1;
    addr  = 8'h40;
    wdata = 32'h0000_00FF;
    repeat (3) begin
      @(posedge clk_in);
      #1;
      chk("rst_leds",   {24'h0, leds},   32'h0);
      chk("rst_rdata",  rdata,           32'h0);
      chk("rst_rvalid", {31'h0, rvalid}, 32'h0);
    end
    reset = 1'b1;
    we    = 1'b0;
    re    = 1'b0;
    step(0, 1, LED_REG_DATA, 32'h0, 32'h0);
    chk("post_rst_leds", {24'h0, leds}, 32'h0);

    foreach (vt[i]) begin
      step(vt[i].w, vt[i].r, vt[i].off, vt[i].wd, vt[i].rd);
      chk($sformatf("vec%0d_leds", i), {24'h0, leds}, {24'h0, vt[i].leds});
    end

    // blink with half-period 4; upper wdata bits of MODE/PERIOD must be dropped
    step(1, 0, LED_REG_DATA, 32'h0000_00FF, 32'h0);
    step(1, 0, LED_REG_MODE, 32'hFFFF_FF0F, 32'h0);
    chk("mode_wr_leds", {24'h0, leds}, 32'hFF);
    step(0, 1, LED_REG_MODE, 32'h0, 32'h0000_000F);
    step(1, 0, LED_REG_PERIOD, 32'hFF00_0004, 32'h0);
    chk("p4_wr_leds", {24'h0, leds}, 32'hFF);
    for (int j = 1; j <= 13; j++) begin
      step(0, j == 1, LED_REG_PERIOD, 32'h0, 32'h0000_0004);
      chk($sformatf("p4_c%0d_leds", j), {24'h0, leds},
          ((((j - 1) / 4) % 2) == 0) ? 32'hFF : 32'hF0);
    end

    // PERIOD=0 written while phase is low: restores the on-state next edge
    step(1, 0, LED_REG_PERIOD, 32'h0, 32'h0);
    chk("p0_wr_leds", {24'h0, leds}, 32'hF0);
    for (int j = 1; j <= 6; j++) begin
      step(0, 0, LED_REG_DATA, 32'h0, 32'h0);
      chk($sformatf("p0_c%0d_leds", j), {24'h0, leds}, 32'hFF);
    end

    step(1, 0, LED_REG_PERIOD, 32'h1, 32'h0);
    chk("p1_wr_leds", {24'h0, leds}, 32'hFF);
    for (int j = 1; j <= 8; j++) begin
      step(0, j == 8, LED_REG_PERIOD, 32'h0, 32'h1);
      chk($sformatf("p1_c%0d_leds", j), {24'h0, leds}, (j % 2 == 1) ? 32'hFF : 32'hF0);
    end

    // reset while blinking with a read strobe present
    reset = 1'b0;
    re    = 1'b1;
    addr  = 8'h40;
    @(posedge clk_in);
    #1;
    reset = 1'b1;
    re    = 1'b0;
    chk("rst2_leds",   {24'h0, leds},   32'h0);
    chk("rst2_rdata",  rdata,           32'h0);
    chk("rst2_rvalid", {31'h0, rvalid}, 32'h0);
    step(0, 1, LED_REG_PERIOD, 32'h0, 32'h0);
    step(0, 1, LED_REG_MODE,   32'h0, 32'h0);
    step(0, 1, LED_REG_DATA,   32'h0, 32'h0);
    chk("rst2_leds_after", {24'h0, leds}, 32'h0);
    repeat (3) step(0, 0, LED_REG_DATA, 32'h0, 32'h0);
    chk("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
